// File: rtl/modulo_down_sequencer_if.sv
// Handshake and index bundle between a controller and modulo_down_sequencer.
interface modulo_down_sequencer_if #(
    parameter int word_len = 8,
    parameter int pass_len = 4
);
    logic                start;
    logic [pass_len-1:0] passes;
    logic                cnt_en;
    logic                clr;
    logic [word_len-1:0] out;
    logic [pass_len-1:0] passes_left;
    logic                bout;
    logic                busy;
    logic                done;

    modport master (
        output start, passes, cnt_en, clr,
        input  out, passes_left, bout, busy, done
    );

    modport slave (
        input  start, passes, cnt_en, clr,
        output out, passes_left, bout, busy, done
    );
endinterface

// File: rtl/modulo_down_sequencer.sv
// Modulo down-counter that replays sample indices divisor-1..0 for a requested
// number of passes, with borrow flag and start/busy/done handshake.
module modulo_down_sequencer #(
    parameter int word_len = 8,
    parameter int divisor  = 150,
    parameter int pass_len = 4
) (
    input logic                  clk,
    input logic                  rst,
    modulo_down_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [word_len-1:0] top_idx = word_len'(divisor - 1);

    state_t              state;
    logic [word_len-1:0] idx;
    logic [pass_len-1:0] pl;

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            state <= IDLE;
            idx   <= '0;
            pl    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        idx   <= top_idx;
                        pl    <= bus.passes;
                        state <= (bus.passes != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (bus.cnt_en) begin
                        if (idx != '0) begin
                            idx <= idx - word_len'(1);
                        end else begin
                            // passes_left is never 0 while running, so this cannot underflow
                            idx <= top_idx;
                            pl  <= pl - pass_len'(1);
                            if (pl == pass_len'(1))
                                state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out         = idx;
    assign bus.passes_left = pl;
    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == DONE);
    assign bus.bout        = (state == RUN) && (idx == '0);
endmodule

// File: tb/tb_modulo_down_sequencer.sv
// Drives three sequencers (divisor 150, 4, 1) in lockstep and compares them
// every cycle against a remaining-steps reference model.
module tb_modulo_down_sequencer;
    logic       clk = 1'b0;
    logic       rst, start, clr, cnt_en;
    logic [3:0] passes;

    always #5 clk = ~clk;

    modulo_down_sequencer_if #(.word_len(8), .pass_len(4)) b150 ();
    modulo_down_sequencer_if #(.word_len(8), .pass_len(4)) b4 ();
    modulo_down_sequencer_if #(.word_len(8), .pass_len(4)) b1 ();

    assign b150.start = start;  assign b150.passes = passes;
    assign b150.cnt_en = cnt_en; assign b150.clr = clr;
    assign b4.start = start;    assign b4.passes = passes;
    assign b4.cnt_en = cnt_en;   assign b4.clr = clr;
    assign b1.start = start;    assign b1.passes = passes;
    assign b1.cnt_en = cnt_en;   assign b1.clr = clr;

    modulo_down_sequencer #(.word_len(8), .divisor(150), .pass_len(4)) dut150 (.clk(clk), .rst(rst), .bus(b150));
    modulo_down_sequencer #(.word_len(8), .divisor(4),   .pass_len(4)) dut4   (.clk(clk), .rst(rst), .bus(b4));
    modulo_down_sequencer #(.word_len(8), .divisor(1),   .pass_len(4)) dut1   (.clk(clk), .rst(rst), .bus(b1));

    logic [14:0] act [3];
    assign act[0] = {b150.out, b150.passes_left, b150.bout, b150.busy, b150.done};
    assign act[1] = {b4.out,   b4.passes_left,   b4.bout,   b4.busy,   b4.done};
    assign act[2] = {b1.out,   b1.passes_left,   b1.bout,   b1.busy,   b1.done};

    int n_cmp = 0;
    int n_err = 0;

    // Model: a run is just a count of enabled steps still owed (passes*divisor).
    int divs [3] = '{150, 4, 1};
    int rem [3];
    bit running [3];
    bit done_m [3];
    int idle_out [3];
    int idle_pl [3];

    function automatic logic [14:0] exp_vec(int k);
        int d = divs[k];
        int o, pl;
        bit bo, by, dn;
        if (running[k]) begin
            o  = (rem[k] - 1) % d;
            pl = (rem[k] + d - 1) / d;
            by = 1'b1; bo = (o == 0); dn = 1'b0;
        end else begin
            o  = idle_out[k];
            pl = idle_pl[k];
            by = 1'b0; bo = 1'b0; dn = done_m[k];
        end
        return {8'(o), 4'(pl), bo, by, dn};
    endfunction

    function automatic void model_step();
        for (int k = 0; k < 3; k++) begin
            if (rst || clr) begin
                running[k] = 0; done_m[k] = 0; idle_out[k] = 0; idle_pl[k] = 0;
            end else if (done_m[k]) begin
                done_m[k] = 0;
            end else if (running[k]) begin
                if (cnt_en) begin
                    rem[k]--;
                    if (rem[k] == 0) begin
                        running[k] = 0; done_m[k] = 1;
                        idle_out[k] = divs[k] - 1; idle_pl[k] = 0;
                    end
                end
            end else if (start) begin
                idle_out[k] = divs[k] - 1;
                if (passes != 0) begin
                    running[k] = 1; rem[k] = int'(passes) * divs[k];
                end else begin
                    idle_pl[k] = 0; done_m[k] = 1;
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic quiet();
        rst = 0; clr = 0; start = 0; cnt_en = 0; passes = '0;
    endtask

    task automatic go_idle();
        quiet(); clr = 1; tick(); clr = 0;
    endtask

    task automatic test_reset();
        quiet(); rst = 1;
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (act[k] !== 15'h0 || act[k] !== exp_vec(k)) begin
                n_err++;
                $display("FAIL reset inst%0d: got %h want %h", k, act[k], exp_vec(k));
            end
        end
        rst = 0;
    endtask

    task automatic test_single_pass();
        int bouts = 0, dones = 0;
        go_idle();
        start = 1; passes = 4'd1; tick(); start = 0; cnt_en = 1;
        for (int i = 0; i < 152; i++) begin
            if (b150.bout) bouts++;
            if (b150.done) dones++;
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (act[k] !== exp_vec(k)) begin
                    n_err++;
                    $display("FAIL single_pass inst%0d cyc%0d: got %h want %h", k, i, act[k], exp_vec(k));
                end
            end
            tick();
        end
        n_cmp++;
        if (bouts != 1 || dones != 1 || b150.out !== 8'd149 || b150.busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_pass_summary: bout=%0d done=%0d out=%0d busy=%b want 1 1 149 0",
                     bouts, dones, b150.out, b150.busy);
        end
    endtask

    task automatic test_multi_pass();
        int done_cyc = -1;
        go_idle();
        start = 1; passes = 4'd3; tick(); start = 0; cnt_en = 1;
        for (int i = 1; i <= 16; i++) begin
            if (b4.done && done_cyc < 0) done_cyc = i;
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (act[k] !== exp_vec(k)) begin
                    n_err++;
                    $display("FAIL multi_pass inst%0d cyc%0d: got %h want %h", k, i, act[k], exp_vec(k));
                end
            end
            tick();
        end
        n_cmp++;
        if (done_cyc != 13) begin
            n_err++;
            $display("FAIL multi_pass_done_cycle: got %0d want 13", done_cyc);
        end
    endtask

    task automatic test_toggle_enable();
        int done_cyc = -1;
        bit bout_hold = 0;
        go_idle();
        start = 1; passes = 4'd2; tick(); start = 0;
        for (int i = 1; i <= 18; i++) begin
            cnt_en = i[0];
            if (b4.done && done_cyc < 0) done_cyc = i;
            if (!cnt_en && b4.bout) bout_hold = 1;
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (act[k] !== exp_vec(k)) begin
                    n_err++;
                    $display("FAIL toggle_enable inst%0d cyc%0d: got %h want %h", k, i, act[k], exp_vec(k));
                end
            end
            tick();
        end
        n_cmp++;
        if (done_cyc != 16 || !bout_hold) begin
            n_err++;
            $display("FAIL toggle_enable_timing: done_cyc=%0d bout_hold=%b want 16 1", done_cyc, bout_hold);
        end
    endtask

    task automatic test_zero_passes();
        go_idle();
        start = 1; passes = 4'd0; tick(); start = 0;
        n_cmp++;
        if (act[0] !== {8'd149, 4'd0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL zero_passes: got %h want %h", act[0], {8'd149, 4'd0, 3'b001});
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (act[k] !== exp_vec(k)) begin
                n_err++;
                $display("FAIL zero_passes_after inst%0d: got %h want %h", k, act[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_clr_mid();
        int dones = 0;
        go_idle();
        start = 1; passes = 4'd2; tick(); start = 0; cnt_en = 1; tick();
        n_cmp++;
        if (b4.out !== 8'd2) begin
            n_err++;
            $display("FAIL clr_setup: got out=%0d want 2", b4.out);
        end
        clr = 1; tick(); clr = 0;
        for (int i = 0; i < 3; i++) begin
            if (b4.done || b150.done) dones++;
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (act[k] !== exp_vec(k) || act[k] !== 15'h0) begin
                    n_err++;
                    $display("FAIL clr_mid inst%0d: got %h want %h", k, act[k], exp_vec(k));
                end
            end
            tick();
        end
        n_cmp++;
        if (dones != 0) begin
            n_err++;
            $display("FAIL clr_no_done: got %0d done pulses want 0", dones);
        end
    endtask

    task automatic test_rst_mid();
        go_idle();
        start = 1; passes = 4'd3; tick(); start = 0; cnt_en = 1;
        tick(); tick(); tick();
        rst = 1; tick(); rst = 0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (act[k] !== 15'h0 || act[k] !== exp_vec(k)) begin
                n_err++;
                $display("FAIL rst_mid inst%0d: got %h want 0", k, act[k]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int dones = 0;
        go_idle();
        start = 1; passes = 4'd1; tick(); cnt_en = 1;
        for (int i = 1; i <= 8; i++) begin
            start = (i <= 2); passes = 4'd3;
            if (b4.done) dones++;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (act[k] !== exp_vec(k)) begin
                    n_err++;
                    $display("FAIL start_ignored inst%0d cyc%0d: got %h want %h", k, i, act[k], exp_vec(k));
                end
            end
            tick();
        end
        start = 0;
        n_cmp++;
        if (dones != 1) begin
            n_err++;
            $display("FAIL start_ignored_done: got %0d want 1", dones);
        end
    endtask

    task automatic test_random();
        go_idle();
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 299) == 0);
            clr    = ($urandom_range(0, 149) == 0);
            start  = ($urandom_range(0, 3) == 0);
            passes = 4'($urandom_range(0, 3));
            cnt_en = ($urandom_range(0, 3) != 0);
            tick();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (act[k] !== exp_vec(k)) begin
                    n_err++;
                    $display("FAIL random inst%0d cyc%0d: got %h want %h", k, i, act[k], exp_vec(k));
                end
            end
        end
        quiet();
    endtask

    initial begin
        quiet(); rst = 1;
        @(negedge clk);
        test_reset();
        test_single_pass();
        test_multi_pass();
        test_toggle_enable();
        test_zero_passes();
        test_clr_mid();
        test_rst_mid();
        test_start_ignored();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
